// File: rtl/snake_body_engine_if.sv
// Step-request / plot bus of the snake body engine; master drives step requests, slave returns plots and status.
interface snake_body_engine_if #(
  parameter int X_W   = 8,
  parameter int Y_W   = 7,
  parameter int LEN_W = 6
);
  logic             go;
  logic [1:0]       dir_in;
  logic             grow;
  logic [2:0]       colour_in;
  logic             ready;
  logic [X_W-1:0]   x;
  logic [Y_W-1:0]   y;
  logic [2:0]       colour_out;
  logic             plot_en;
  logic [X_W-1:0]   head_x;
  logic [Y_W-1:0]   head_y;
  logic [LEN_W:0]   length;
  logic             step_done;
  logic             is_dead;

  modport master (
    output go, dir_in, grow, colour_in,
    input  ready, x, y, colour_out, plot_en, head_x, head_y, length, step_done, is_dead
  );

  modport slave (
    input  go, dir_in, grow, colour_in,
    output ready, x, y, colour_out, plot_en, head_x, head_y, length, step_done, is_dead
  );
endinterface

// File: rtl/snake_body_engine.sv
// Snake body engine: one step per accepted go (move, self/edge check, erase tail, draw head); step_done length+4 cycles after go.
// go is honoured only while ready (IDLE) and ignored in every other state; death is sticky until reset.
module snake_body_engine #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int X_MAX    = 159,
  parameter int Y_MAX    = 119,
  parameter int LEN_W    = 6,
  parameter int INIT_LEN = 3,
  parameter int INIT_X   = 80,
  parameter int INIT_Y   = 60,
  parameter int WRAP     = 0
) (
  input logic                clk,
  input logic                reset_n,
  snake_body_engine_if.slave bus
);
  localparam int MAX_LEN = 1 << LEN_W;

  localparam logic [X_W-1:0]   X_MAX_C  = X_W'(X_MAX);
  localparam logic [Y_W-1:0]   Y_MAX_C  = Y_W'(Y_MAX);
  localparam logic [X_W-1:0]   X_ONE    = X_W'(1);
  localparam logic [Y_W-1:0]   Y_ONE    = Y_W'(1);
  localparam logic [X_W-1:0]   X_INIT   = X_W'(INIT_X);
  localparam logic [Y_W-1:0]   Y_INIT   = Y_W'(INIT_Y);
  localparam logic [LEN_W:0]   LEN_ONE  = (LEN_W+1)'(1);
  localparam logic [LEN_W:0]   LEN_FULL = (LEN_W+1)'(MAX_LEN);
  localparam logic [LEN_W:0]   LEN_INIT = (LEN_W+1)'(INIT_LEN);
  localparam logic [LEN_W-1:0] PTR_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0] PTR_INIT = LEN_W'(INIT_LEN - 1);

  localparam logic [1:0] DIR_R = 2'b00;
  localparam logic [1:0] DIR_U = 2'b01;
  localparam logic [1:0] DIR_L = 2'b10;

  typedef enum logic [2:0] {IDLE, MOVE, CHECK, ERASE, DRAW, DONE, DEAD} state_t;

  state_t           state;
  logic [X_W-1:0]   body_x [MAX_LEN];
  logic [Y_W-1:0]   body_y [MAX_LEN];
  logic [LEN_W-1:0] head_ptr;
  logic [LEN_W:0]   len;
  logic [LEN_W:0]   scan_cnt;
  logic [1:0]       heading;
  logic             grow_l;
  logic [2:0]       colour_l;
  logic [X_W-1:0]   head_x_r, nx, x_r;
  logic [Y_W-1:0]   head_y_r, ny, y_r;
  logic [2:0]       colour_r;
  logic             plot_r, done_r, dead_r, hit;

  logic [LEN_W:0]   len_m1;
  logic [LEN_W-1:0] scan_ptr, tail_ptr, next_ptr;
  logic             scan_last, scan_match;

  // Scan walks from the head backwards; the last entry visited is the tail.
  always_comb begin
    len_m1     = len - LEN_ONE;
    scan_ptr   = head_ptr - scan_cnt[LEN_W-1:0];
    tail_ptr   = head_ptr - len_m1[LEN_W-1:0];
    next_ptr   = head_ptr + PTR_ONE;
    scan_last  = (scan_cnt == len_m1);
    scan_match = (body_x[scan_ptr] == nx) && (body_y[scan_ptr] == ny) && !(scan_last && !grow_l);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      heading  <= DIR_R;
      len      <= LEN_INIT;
      head_ptr <= PTR_INIT;
      head_x_r <= X_INIT;
      head_y_r <= Y_INIT;
      nx       <= '0;
      ny       <= '0;
      scan_cnt <= '0;
      hit      <= 1'b0;
      grow_l   <= 1'b0;
      colour_l <= '0;
      x_r      <= '0;
      y_r      <= '0;
      colour_r <= '0;
      plot_r   <= 1'b0;
      done_r   <= 1'b0;
      dead_r   <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        if (i < INIT_LEN) begin
          body_x[i] <= X_W'(INIT_X - INIT_LEN + 1 + i);
          body_y[i] <= Y_INIT;
        end else begin
          body_x[i] <= '0;
          body_y[i] <= '0;
        end
      end
    end else begin
      plot_r <= 1'b0;
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.go) begin
            if (bus.dir_in != (heading ^ 2'b10)) heading <= bus.dir_in;
            grow_l   <= bus.grow && (len != LEN_FULL);
            colour_l <= bus.colour_in;
            state    <= MOVE;
          end
        end
        MOVE: begin
          scan_cnt <= '0;
          hit      <= 1'b0;
          nx       <= head_x_r;
          ny       <= head_y_r;
          state    <= CHECK;
          case (heading)
            DIR_R: begin
              if (head_x_r != X_MAX_C)  nx <= head_x_r + X_ONE;
              else if (WRAP != 0)       nx <= '0;
              else begin state <= DEAD; dead_r <= 1'b1; end
            end
            DIR_L: begin
              if (head_x_r != '0)       nx <= head_x_r - X_ONE;
              else if (WRAP != 0)       nx <= X_MAX_C;
              else begin state <= DEAD; dead_r <= 1'b1; end
            end
            DIR_U: begin
              if (head_y_r != '0)       ny <= head_y_r - Y_ONE;
              else if (WRAP != 0)       ny <= Y_MAX_C;
              else begin state <= DEAD; dead_r <= 1'b1; end
            end
            default: begin
              if (head_y_r != Y_MAX_C)  ny <= head_y_r + Y_ONE;
              else if (WRAP != 0)       ny <= '0;
              else begin state <= DEAD; dead_r <= 1'b1; end
            end
          endcase
        end
        CHECK: begin
          if (scan_match) hit <= 1'b1;
          scan_cnt <= scan_cnt + LEN_ONE;
          if (scan_last) begin
            if (hit || scan_match) begin
              state  <= DEAD;
              dead_r <= 1'b1;
            end else begin
              state <= ERASE;
            end
          end
        end
        ERASE: begin
          // Growing keeps the tail in place: length rises while the head pointer advances.
          if (grow_l) begin
            len <= len + LEN_ONE;
          end else begin
            x_r      <= body_x[tail_ptr];
            y_r      <= body_y[tail_ptr];
            colour_r <= '0;
            plot_r   <= 1'b1;
          end
          state <= DRAW;
        end
        DRAW: begin
          head_ptr         <= next_ptr;
          body_x[next_ptr] <= nx;
          body_y[next_ptr] <= ny;
          head_x_r         <= nx;
          head_y_r         <= ny;
          x_r              <= nx;
          y_r              <= ny;
          colour_r         <= colour_l;
          plot_r           <= 1'b1;
          state            <= DONE;
        end
        DONE: begin
          done_r <= 1'b1;
          state  <= IDLE;
        end
        DEAD:    state <= DEAD;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready      = (state == IDLE);
  assign bus.x          = x_r;
  assign bus.y          = y_r;
  assign bus.colour_out = colour_r;
  assign bus.plot_en    = plot_r;
  assign bus.head_x     = head_x_r;
  assign bus.head_y     = head_y_r;
  assign bus.length     = len;
  assign bus.step_done  = done_r;
  assign bus.is_dead    = dead_r;
endmodule

// File: tb/tb_snake_body_engine.sv
// Directed bench: a WRAP=0 and a WRAP=1 engine share one step stream; step vectors from a table plus hand-built corner sequences.
module tb_snake_body_engine;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic       go = 1'b0;
  logic [1:0] dir = 2'b00;
  logic       grow = 1'b0;
  logic [2:0] col = 3'b000;

  snake_body_engine_if #(.X_W(8), .Y_W(7), .LEN_W(6)) b0 ();
  snake_body_engine_if #(.X_W(8), .Y_W(7), .LEN_W(6)) b1 ();

  assign b0.go = go;  assign b0.dir_in = dir;  assign b0.grow = grow;  assign b0.colour_in = col;
  assign b1.go = go;  assign b1.dir_in = dir;  assign b1.grow = grow;  assign b1.colour_in = col;

  snake_body_engine #(.WRAP(0)) d0 (.clk(clk), .reset_n(reset_n), .bus(b0.slave));
  snake_body_engine #(.WRAP(1)) d1 (.clk(clk), .reset_n(reset_n), .bus(b1.slave));

  typedef struct {int x; int y; int c;} plot_t;
  plot_t q0[$];
  plot_t q1[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_go = 0;
  int l0, l1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (b0.plot_en) q0.push_back('{int'(b0.x), int'(b0.y), int'(b0.colour_out)});
    if (b1.plot_en) q1.push_back('{int'(b1.x), int'(b1.y), int'(b1.colour_out)});
  end

  typedef struct {
    bit         rst;
    logic [1:0] dir;
    logic       grow;
    logic [2:0] col;
    int hx, hy, len, lat, nplot, ex, ey, dead;
  } vec_t;

  localparam int NV = 16;
  vec_t tbl [NV];

  function automatic vec_t mk(bit r, logic [1:0] d, logic g, logic [2:0] c,
                              int hx, int hy, int len, int lat, int np, int ex, int ey, int dead);
    vec_t v;
    v.rst = r; v.dir = d; v.grow = g; v.col = c;
    v.hx = hx; v.hy = hy; v.len = len; v.lat = lat; v.nplot = np; v.ex = ex; v.ey = ey; v.dead = dead;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    go = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    q0.delete();
    q1.delete();
  endtask

  task automatic start_go(input logic [1:0] d, input logic g, input logic [2:0] c);
    @(negedge clk);
    q0.delete();
    q1.delete();
    dir = d; grow = g; col = c; go = 1'b1;
    @(posedge clk);
    #1;
    n_go = cyc;
    go = 1'b0;
  endtask

  task automatic wait_done(output int lat0, output int lat1);
    lat0 = -1;
    lat1 = -1;
    for (int k = 0; k < 150; k++) begin
      @(posedge clk);
      #1;
      if (lat0 < 0 && b0.step_done) lat0 = cyc - n_go;
      if (lat1 < 0 && b1.step_done) lat1 = cyc - n_go;
      if (lat0 >= 0 && lat1 >= 0) break;
    end
  endtask

  task automatic run_vec(input vec_t v, input int i);
    if (v.rst) do_reset();
    start_go(v.dir, v.grow, v.col);
    wait_done(l0, l1);
    chk($sformatf("v%0d_latency", i), l0, v.lat);
    chk($sformatf("v%0d_head_x", i), int'(b0.head_x), v.hx);
    chk($sformatf("v%0d_head_y", i), int'(b0.head_y), v.hy);
    chk($sformatf("v%0d_length", i), int'(b0.length), v.len);
    chk($sformatf("v%0d_is_dead", i), int'(b0.is_dead), v.dead);
    chk($sformatf("v%0d_plot_count", i), q0.size(), v.nplot);
    if (q0.size() == v.nplot && v.nplot == 2) begin
      chk($sformatf("v%0d_erase_x", i), q0[0].x, v.ex);
      chk($sformatf("v%0d_erase_y", i), q0[0].y, v.ey);
      chk($sformatf("v%0d_erase_c", i), q0[0].c, 0);
    end
    if (q0.size() == v.nplot && v.nplot >= 1) begin
      chk($sformatf("v%0d_draw_x", i), q0[v.nplot-1].x, v.hx);
      chk($sformatf("v%0d_draw_y", i), q0[v.nplot-1].y, v.hy);
      chk($sformatf("v%0d_draw_c", i), q0[v.nplot-1].c, int'(v.col));
    end
  endtask

  initial begin
    int bad;
    // Straight steps, a reversal, four grows, then an erase of the oldest cell.
    tbl[0]  = mk(1, 2'd0, 1'b0, 3'd5, 81, 60, 3,  7, 2, 78, 60, 0);
    tbl[1]  = mk(0, 2'd2, 1'b0, 3'd3, 82, 60, 3,  7, 2, 79, 60, 0);
    tbl[2]  = mk(0, 2'd3, 1'b1, 3'd1, 82, 61, 4,  7, 1,  0,  0, 0);
    tbl[3]  = mk(0, 2'd3, 1'b1, 3'd2, 82, 62, 5,  8, 1,  0,  0, 0);
    tbl[4]  = mk(0, 2'd0, 1'b1, 3'd6, 83, 62, 6,  9, 1,  0,  0, 0);
    tbl[5]  = mk(0, 2'd1, 1'b1, 3'd7, 83, 61, 7, 10, 1,  0,  0, 0);
    tbl[6]  = mk(0, 2'd1, 1'b0, 3'd4, 83, 60, 7, 11, 2, 80, 60, 0);
    // Length-4 loop: the last step enters the vacating tail cell and survives.
    tbl[7]  = mk(1, 2'd0, 1'b1, 3'd1, 81, 60, 4,  7, 1,  0,  0, 0);
    tbl[8]  = mk(0, 2'd1, 1'b0, 3'd2, 81, 59, 4,  8, 2, 78, 60, 0);
    tbl[9]  = mk(0, 2'd2, 1'b0, 3'd3, 80, 59, 4,  8, 2, 79, 60, 0);
    tbl[10] = mk(0, 2'd3, 1'b0, 3'd4, 80, 60, 4,  8, 2, 80, 60, 0);
    // Length-5 body: up, left, down bites the body.
    tbl[11] = mk(1, 2'd0, 1'b1, 3'd1, 81, 60, 4,  7, 1,  0,  0, 0);
    tbl[12] = mk(0, 2'd0, 1'b1, 3'd2, 82, 60, 5,  8, 1,  0,  0, 0);
    tbl[13] = mk(0, 2'd1, 1'b0, 3'd3, 82, 59, 5,  9, 2, 78, 60, 0);
    tbl[14] = mk(0, 2'd2, 1'b0, 3'd4, 81, 59, 5,  9, 2, 79, 60, 0);
    tbl[15] = mk(0, 2'd3, 1'b0, 3'd5, 81, 59, 5, -1, 0,  0,  0, 1);

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", int'(b0.ready), 1);
    chk("rst_plot_en", int'(b0.plot_en), 0);
    chk("rst_step_done", int'(b0.step_done), 0);
    chk("rst_is_dead", int'(b0.is_dead), 0);
    chk("rst_x", int'(b0.x), 0);
    chk("rst_y", int'(b0.y), 0);
    chk("rst_colour", int'(b0.colour_out), 0);
    chk("rst_head_x", int'(b0.head_x), 80);
    chk("rst_head_y", int'(b0.head_y), 60);
    chk("rst_length", int'(b0.length), 3);
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) run_vec(tbl[i], i);

    // Dead engine ignores go.
    start_go(2'd0, 1'b0, 3'd1);
    repeat (20) @(posedge clk);
    #1;
    chk("dead_go_head_x", int'(b0.head_x), 81);
    chk("dead_go_head_y", int'(b0.head_y), 59);
    chk("dead_go_length", int'(b0.length), 5);
    chk("dead_go_plots", q0.size(), 0);
    chk("dead_go_ready", int'(b0.ready), 0);

    // go pulsed during CHECK must not steer: a later left request is still a reversal.
    do_reset();
    start_go(2'd0, 1'b0, 3'd2);
    @(posedge clk);
    #1;
    dir = 2'd1; go = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
    wait_done(l0, l1);
    chk("chkgo_latency", l0, 7);
    chk("chkgo_head_x", int'(b0.head_x), 81);
    chk("chkgo_head_y", int'(b0.head_y), 60);
    chk("chkgo_plots", q0.size(), 2);
    start_go(2'd2, 1'b0, 3'd3);
    wait_done(l0, l1);
    chk("chkgo_next_head_x", int'(b0.head_x), 82);
    chk("chkgo_next_head_y", int'(b0.head_y), 60);

    // Reset asserted mid-CHECK aborts the step immediately.
    start_go(2'd0, 1'b0, 3'd4);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_ready", int'(b0.ready), 1);
    chk("midrst_head_x", int'(b0.head_x), 80);
    chk("midrst_length", int'(b0.length), 3);
    chk("midrst_plot_en", int'(b0.plot_en), 0);
    @(negedge clk);
    reset_n = 1'b1;
    q0.delete();
    repeat (12) @(posedge clk);
    #1;
    chk("midrst_no_plots", q0.size(), 0);
    chk("midrst_still_ready", int'(b0.ready), 1);
    start_go(2'd0, 1'b0, 3'd5);
    wait_done(l0, l1);
    chk("midrst_step_latency", l0, 7);
    chk("midrst_erase_x", (q0.size() == 2) ? q0[0].x : -1, 78);
    chk("midrst_head_x", int'(b0.head_x), 81);

    // Walk both engines to the right edge, then one more step right.
    do_reset();
    bad = 0;
    for (int s = 0; s < 79; s++) begin
      start_go(2'd0, 1'b0, 3'd1);
      wait_done(l0, l1);
      if (l0 != 7 || l1 != 7) bad++;
    end
    chk("walk_bad_latencies", bad, 0);
    chk("walk_d0_head_x", int'(b0.head_x), 159);
    chk("walk_d1_head_x", int'(b1.head_x), 159);
    start_go(2'd0, 1'b0, 3'd6);
    wait_done(l0, l1);
    chk("wrap_latency", l1, 7);
    chk("wrap_head_x", int'(b1.head_x), 0);
    chk("wrap_head_y", int'(b1.head_y), 60);
    chk("wrap_draw_x", (q1.size() == 2) ? q1[1].x : -1, 0);
    chk("edge_no_step_done", l0, -1);
    chk("edge_is_dead", int'(b0.is_dead), 1);
    chk("edge_no_plots", q0.size(), 0);
    chk("edge_head_x", int'(b0.head_x), 159);
    start_go(2'd3, 1'b0, 3'd2);
    repeat (20) @(posedge clk);
    #1;
    chk("edge_go_ignored_head_y", int'(b0.head_y), 60);
    chk("edge_go_ignored_plots", q0.size(), 0);
    chk("edge_ready_low", int'(b0.ready), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1);
  end
endmodule

// File: doc/snake_body_engine.md
SNAKE_BODY_ENGINE -- requirements
Module: snake_body_engine

Interface
REQ-001 Parameter X_W, default 8, x coordinate width.
REQ-002 Parameter Y_W, default 7, y coordinate width.
REQ-003 Parameter X_MAX, default 159, largest legal x.
REQ-004 Parameter Y_MAX, default 119, largest legal y.
REQ-005 Parameter LEN_W, default 6, buffer address width; MAX_LEN = 2**LEN_W segments.
REQ-006 Parameter INIT_LEN, default 3, segments present after reset (2..MAX_LEN).
REQ-007 Parameter INIT_X/INIT_Y, defaults 80/60, head position after reset.
REQ-008 Parameter WRAP, default 0, edge mode: 1 = wrap-around, 0 = edge is lethal.
REQ-009 clk  in  1  single clock, all state on rising edge.
REQ-010 reset_n  in  1  asynchronous, active-low reset.
REQ-011 go  in  1  step request; accepted only when ready=1.
REQ-012 dir_in  in  2  requested heading: 00 right, 01 up (y-1), 10 left, 11 down (y+1).
REQ-013 grow  in  1  sampled with go; the accepted step lengthens the body by one.
REQ-014 colour_in  in  3  head draw colour, sampled with go.
REQ-015 ready  out  1  high only in IDLE.
REQ-016 x / y  out  X_W / Y_W  registered plot coordinate.
REQ-017 colour_out  out  3  registered plot colour.
REQ-018 plot_en  out  1  one-cycle plot strobe qualifying x/y/colour_out.
REQ-019 head_x / head_y  out  X_W / Y_W  current head position.
REQ-020 length  out  LEN_W+1  current segment count.
REQ-021 step_done  out  1  one-cycle pulse at the end of a step.
REQ-022 is_dead  out  1  sticky death flag.

Function
REQ-023 Body SHALL be held in a MAX_LEN-entry circular buffer indexed by a head pointer and length; the tail is at head_ptr-(length-1) modulo MAX_LEN.
REQ-024 FSM states SHALL be IDLE, MOVE, CHECK, ERASE, DRAW, DONE, DEAD.
REQ-025 IDLE: go=1 SHALL latch dir_in, grow and colour_in and transition to MOVE; go is ignored in every other state.
REQ-026 Heading update: a dir_in opposite to the current heading SHALL be ignored (heading retained); any other value becomes the heading.
REQ-027 MOVE (1 cycle): next head = head +/- 1 on one axis; WRAP=1: x beyond X_MAX -> 0, x below 0 -> X_MAX (same for y with Y_MAX); WRAP=0: leaving 0..X_MAX or 0..Y_MAX -> DEAD.
REQ-028 CHECK (exactly `length` cycles, one buffer entry per cycle) compares the next head with each segment; the tail entry is excluded when grow is not latched; any match -> DEAD after the scan.
REQ-029 ERASE (1 cycle): if not growing, SHALL output the tail at colour 000 with plot_en=1 and advance the tail; if growing, plot_en=0 and length increments.
REQ-030 grow at length==MAX_LEN SHALL be treated as grow=0 (length saturates).
REQ-031 DRAW (1 cycle): SHALL write the next head into the buffer, update head_x/head_y, and output the head at the latched colour with plot_en=1.
REQ-032 DONE (1 cycle): step_done=1, then IDLE.
REQ-033 Latency: go accepted at edge N -> step_done high in cycle N+length+4, where length is the pre-step value.
REQ-034 DEAD: is_dead=1, ready=0, plot_en=0, no buffer, head or length change; exit only via reset.
REQ-035 Entry to DEAD SHALL NOT produce ERASE/DRAW plots or step_done.

Reset
REQ-036 reset_n low SHALL asynchronously force IDLE, heading right, length=INIT_LEN, plot_en=0, step_done=0, is_dead=0, x=y=0, colour_out=000.
REQ-037 After reset, the buffer SHALL hold a horizontal body with head (INIT_X,INIT_Y) and tail (INIT_X-INIT_LEN+1,INIT_Y); head_x/head_y = INIT_X/INIT_Y.
REQ-038 Reset mid-step SHALL abort the step with no further plot strobes.

Verification
REQ-039 Reset, go with dir=00 and grow=0 -> erase plot (78,60,000), then draw plot (81,60,colour_in); step_done at N+7; length=3.
REQ-040 From reset, go with dir=10 (reversal) -> heading stays right; head becomes (81,60).
REQ-041 Four steps with grow=1 -> length=7; each ERASE shows plot_en=0; step_done at N+L+4 with the growing L.
REQ-042 WRAP=1: steer the head to x=159 and step right -> head (0,y); WRAP=0 same stimulus -> is_dead=1, no plots, no step_done, go ignored.
REQ-043 Length 5 body: steer up, left, down -> self-hit -> is_dead=1; a move into the vacating tail cell with grow=0 -> alive.
REQ-044 go pulsed during CHECK -> ignored; reset_n asserted during CHECK -> immediate IDLE with initial state.
